ofmap_postproc: RTL

Streaming post-processing stage between the systolic array psum path and the ofmap readout. It takes LANES-wide vectors of 2*WD-bit fixed-point partial sums and applies an arithmetic right shift by FI with saturation to WD bits, optional ReLU, and optional 2x2 stride-2 max-pooling with an internal line buffer. It emits WD-bit pixel vectors on a valid/ready stream and pulses `tile_done` when a configured tile has drained. It is the parametrised successor to the fixed 8-lane combinational truncate/ReLU plus external pooling compare.

---
 rtl/accel_pkg.sv | 21 ++
 rtl/pool_line_buffer.sv | 24 ++
 rtl/ofmap_postproc.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/accel_pkg.sv
// Shared definitions for the accelerator datapath: default widths, psum/pixel
// types, the post-processing state encoding and the default saturation bounds.
package accel_pkg;

  localparam int WD    = 8;
  localparam int FI    = 3;
  localparam int LANES = 8;

  typedef logic signed [2*WD-1:0] psum_t;
  typedef logic signed [WD-1:0]   pixel_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam pixel_t PIX_MAX = {1'b0, {(WD-1){1'b1}}};
  localparam pixel_t PIX_MIN = {1'b1, {(WD-1){1'b0}}};

endpackage

// File: rtl/pool_line_buffer.sv
// Row buffer for 2x2 pooling: one write port and one registered read port.
// Contents are not reset; every entry is written on an even row before it is read.
module pool_line_buffer #(
  parameter int DEPTH = 32,
  parameter int W     = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/ofmap_postproc.sv
// Psum post-processing: shift/saturate, optional ReLU, optional 2x2 max-pool.
// Pooling path is compiled in only when OFMAP_POSTPROC_POOL_EN is defined.
//
// state | meaning
// IDLE  | waiting for cfg_load; config and counters latched on load
// RUN   | accepting psum vectors, row/col counters advance per handshake
// DRAIN | last input taken; wait for the final output, then pulse tile_done
module ofmap_postproc #(
  parameter int WD       = accel_pkg::WD,
  parameter int LANES    = accel_pkg::LANES,
  parameter int FI       = accel_pkg::FI,
  parameter int MAX_COLS = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_load,
  input  logic                  cfg_relu,
  input  logic                  cfg_pool,
  input  logic [5:0]            cfg_rows,
  input  logic [5:0]            cfg_cols,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*2*WD-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES*WD-1:0]   out_data,
  output logic                  tile_done,
  output logic                  busy
);

  localparam int PW       = 2*WD;
  localparam int LB_DEPTH = MAX_COLS/2;
  localparam int LB_AW    = $clog2(LB_DEPTH);
  localparam logic signed [PW-1:0] SAT_HI = {{(WD+1){1'b0}}, {(WD-1){1'b1}}};
  localparam logic signed [PW-1:0] SAT_LO = {{(WD+1){1'b1}}, {(WD-1){1'b0}}};

  accel_pkg::state_t state, state_nxt;

  logic                relu_q;
  logic [5:0]          rows_q, cols_q, row, col;
  logic [LANES*WD-1:0] act_vec, res_vec;
  logic                in_hs, out_hs, last_col, last_in, produce, load;

  assign in_ready = (state == accel_pkg::RUN) && (!out_valid || out_ready);
  assign in_hs    = in_valid && in_ready;
  assign out_hs   = out_valid && out_ready;
  assign busy     = (state != accel_pkg::IDLE);
  assign load     = (state == accel_pkg::IDLE) && cfg_load;
  assign last_col = (col == cols_q - 6'd1);
  assign last_in  = last_col && (row == rows_q - 6'd1);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic signed [PW-1:0] psum, s;
    logic signed [WD-1:0] sat;

    assign psum = in_data[l*PW +: PW];
    assign s    = psum >>> FI;

    always_comb begin
      if (s > SAT_HI)      sat = SAT_HI[WD-1:0];
      else if (s < SAT_LO) sat = SAT_LO[WD-1:0];
      else                 sat = s[WD-1:0];
      if (relu_q && sat[WD-1]) sat = '0;
    end

    assign act_vec[l*WD +: WD] = sat;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      accel_pkg::IDLE:  if (cfg_load) state_nxt = accel_pkg::RUN;
      accel_pkg::RUN:   if (in_hs && last_in) state_nxt = accel_pkg::DRAIN;
      accel_pkg::DRAIN: if (!out_valid || out_ready) state_nxt = accel_pkg::IDLE;
      default:          state_nxt = accel_pkg::IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= accel_pkg::IDLE;
      relu_q    <= 1'b0;
      rows_q    <= '0;
      cols_q    <= '0;
      row       <= '0;
      col       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      tile_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      tile_done <= (state == accel_pkg::DRAIN) && (state_nxt == accel_pkg::IDLE);
      if (load) begin
        relu_q <= cfg_relu;
        rows_q <= cfg_rows;
        cols_q <= cfg_cols;
        row    <= '0;
        col    <= '0;
      end else if (in_hs) begin
        if (last_col) begin
          col <= '0;
          row <= row + 6'd1;
        end else begin
          col <= col + 6'd1;
        end
      end
      if (produce) begin
        out_valid <= 1'b1;
        out_data  <= res_vec;
      end else if (out_hs) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef OFMAP_POSTPROC_POOL_EN
  logic                pool_q;
  logic [LANES*WD-1:0] hreg, pair_vec, lb_rd, pool_vec;

  always_ff @(posedge clk) begin
    if (rst) begin
      pool_q <= 1'b0;
      hreg   <= '0;
    end else begin
      if (load) pool_q <= cfg_pool;
      if (in_hs && !col[0]) hreg <= act_vec;
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_pool
    logic signed [WD-1:0] h, a, p, b;
    assign h = hreg[l*WD +: WD];
    assign a = act_vec[l*WD +: WD];
    assign b = lb_rd[l*WD +: WD];
    assign p = (h > a) ? h : a;
    assign pair_vec[l*WD +: WD] = p;
    assign pool_vec[l*WD +: WD] = (b > p) ? b : p;
  end

  // Read is issued on the even column so the registered data is ready at the odd one.
  pool_line_buffer #(
    .DEPTH (LB_DEPTH),
    .W     (LANES*WD)
  ) u_line_buffer (
    .clk     (clk),
    .wr_en   (in_hs && pool_q && col[0] && !row[0]),
    .wr_addr (col[LB_AW:1]),
    .wr_data (pair_vec),
    .rd_en   (in_hs && pool_q && !col[0] && row[0]),
    .rd_addr (col[LB_AW:1]),
    .rd_data (lb_rd)
  );

  assign produce = pool_q ? (in_hs && col[0] && row[0]) : in_hs;
  assign res_vec = pool_q ? pool_vec : act_vec;
`else
  logic unused_cfg_pool;
  assign unused_cfg_pool = cfg_pool;
  assign produce = in_hs;
  assign res_vec = act_vec;
`endif

endmodule
